dec_entry: RTL and testbench

- Operand-entry front end for the ALU datapath: accepts decimal key strobes (digits, sign, clear, enter) and produces a binary operand of `width` bits.
- Inverse direction of the binary-to-BCD display path: BCD digits in, two's-complement/unsigned binary out.
- Uses a multi-cycle reverse double-dabble converter, followed by a range check.
- Echoes the in-progress entry as BCD codes for the 7-seg display chain.

---
 rtl/dec_entry.sv | 211 +++++++++++++++++++++
 tb/tb_dec_entry.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/dec_entry.sv
// Decimal key entry to binary operand via reverse double-dabble plus range check.
// DEC_ENTRY_BACKSPACE_EN enables key B as backspace.
module dec_entry #(
  parameter int WIDTH  = 6,
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  key_valid,
  input  logic [3:0]            key_code,
  input  logic                  sgn,
  output logic [WIDTH-1:0]      value,
  output logic                  value_valid,
  output logic                  err,
  output logic                  busy,
  output logic [4*DIGITS-1:0]   entry_bcd,
  output logic                  entry_neg
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);
  localparam int NW = $clog2(BW + 1);

  localparam logic [63:0] LIM_U = (64'd1 << WIDTH) - 64'd1;
  localparam logic [63:0] LIM_P = (64'd1 << (WIDTH - 1)) - 64'd1;
  localparam logic [63:0] LIM_N = (64'd1 << (WIDTH - 1));

  typedef enum logic [2:0] {
    EMPTY, ENTRY, CONV, CHECK, DONE, ERR
  } state_e;

  state_e state_q, state_d;

  logic [BW-1:0]    buf_q, buf_d;
  logic [BW-1:0]    work_q, work_d;
  logic [BW-1:0]    mag_q, mag_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [NW-1:0]    ccnt_q, ccnt_d;
  logic             neg_q, neg_d;
  logic             sgn_q, sgn_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             vv_q, vv_d;
  logic             err_q, err_d;

  logic k_dig, k_neg, k_clr, k_ent;
  logic idle, fin, dig_ok, bs_ok;
  logic conv_last, neg_eff, legal;
  logic [63:0]      lim;
  logic [WIDTH-1:0] magw;
  logic [2*BW-1:0]  sh;

  // Blank digits count as zero when the conversion starts.
  function automatic logic [BW-1:0] zfill(input logic [BW-1:0] b);
    logic [BW-1:0] r;
    r = b;
    for (int i = 0; i < DIGITS; i++)
      if (b[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd0;
    return r;
  endfunction

  function automatic logic [BW-1:0] adj(input logic [BW-1:0] b);
    logic [BW-1:0] r;
    r = b;
    for (int i = 0; i < DIGITS; i++)
      if (b[4*i +: 4] >= 4'd8) r[4*i +: 4] = b[4*i +: 4] - 4'd3;
    return r;
  endfunction

  assign k_dig = key_valid && (key_code <= 4'd9);
  assign k_neg = key_valid && (key_code == 4'hA);
  assign k_clr = key_valid && (key_code == 4'hC);
  assign k_ent = key_valid && (key_code == 4'hE);

  assign fin  = (state_q == DONE) || (state_q == ERR);
  assign idle = fin || (state_q == EMPTY) || (state_q == ENTRY);
  assign dig_ok = k_dig && (fin || (cnt_q != CW'(DIGITS)));

`ifdef DEC_ENTRY_BACKSPACE_EN
  assign bs_ok = key_valid && (key_code == 4'hB)
              && (state_q != EMPTY) && (cnt_q != '0);
`else
  assign bs_ok = 1'b0;
`endif

  assign conv_last = (ccnt_q == NW'(BW - 1));
  assign sh        = {work_q, mag_q} >> 1;

  assign neg_eff = sgn_q & neg_q;
  assign lim     = !sgn_q ? LIM_U : (neg_eff ? LIM_N : LIM_P);
  assign legal   = 64'(mag_q) <= lim;
  assign magw    = WIDTH'(mag_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY, ENTRY, DONE, ERR: begin
        if (k_clr)       state_d = EMPTY;
        else if (k_ent)  state_d = CONV;
        else if (dig_ok) state_d = ENTRY;
        else if (bs_ok)  state_d = (cnt_q == CW'(1)) ? EMPTY : ENTRY;
      end
      CONV: begin
        if (k_clr)          state_d = EMPTY;
        else if (conv_last) state_d = CHECK;
      end
      CHECK:   state_d = legal ? DONE : ERR;
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    busy        = (state_q == CONV) || (state_q == CHECK);
    value       = value_q;
    value_valid = vv_q;
    err         = err_q;
    entry_bcd   = buf_q;
    entry_neg   = neg_q;
  end

  always_comb begin
    buf_d   = buf_q;
    work_d  = work_q;
    mag_d   = mag_q;
    cnt_d   = cnt_q;
    ccnt_d  = ccnt_q;
    neg_d   = neg_q;
    sgn_d   = sgn_q;
    value_d = value_q;
    vv_d    = 1'b0;
    err_d   = err_q;
    if (idle) begin
      if (k_clr) begin
        buf_d = '1;
        cnt_d = '0;
        neg_d = 1'b0;
        if (fin) err_d = 1'b0;
      end else if (k_ent) begin
        sgn_d  = sgn;
        work_d = zfill(buf_q);
        mag_d  = '0;
        ccnt_d = '0;
      end else if (dig_ok) begin
        if (fin) begin
          buf_d = ({BW{1'b1}} << 4) | BW'(key_code);
          cnt_d = CW'(1);
          neg_d = 1'b0;
          err_d = 1'b0;
        end else begin
          buf_d = (buf_q << 4) | BW'(key_code);
          cnt_d = cnt_q + CW'(1);
        end
      end else if (k_neg && sgn) begin
        neg_d = ~neg_q;
      end else if (bs_ok) begin
        buf_d = (buf_q >> 4) | {4'hF, {(BW-4){1'b0}}};
        cnt_d = cnt_q - CW'(1);
        if (fin) err_d = 1'b0;
      end
    end else if (state_q == CONV) begin
      if (k_clr) begin
        buf_d = '1;
        cnt_d = '0;
        neg_d = 1'b0;
      end else begin
        work_d = adj(sh[2*BW-1:BW]);
        mag_d  = sh[BW-1:0];
        ccnt_d = ccnt_q + NW'(1);
      end
    end else if (state_q == CHECK) begin
      if (legal) begin
        value_d = neg_eff ? (WIDTH'(0) - magw) : magw;
        vv_d    = 1'b1;
        err_d   = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q   <= '1;
      work_q  <= '0;
      mag_q   <= '0;
      cnt_q   <= '0;
      ccnt_q  <= '0;
      neg_q   <= 1'b0;
      sgn_q   <= 1'b0;
      value_q <= '0;
      vv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      buf_q   <= buf_d;
      work_q  <= work_d;
      mag_q   <= mag_d;
      cnt_q   <= cnt_d;
      ccnt_q  <= ccnt_d;
      neg_q   <= neg_d;
      sgn_q   <= sgn_d;
      value_q <= value_d;
      vv_q    <= vv_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_dec_entry.sv
// Directed bench for dec_entry: conversion, sign ranges, limits, abort,
// empty entry and key B behaviour.
module tb_dec_entry;

  logic       clk;
  logic       rst_n;
  logic       key_valid;
  logic [3:0] key_code;
  logic       sgn;
  logic [5:0] value;
  logic       value_valid;
  logic       err;
  logic       busy;
  logic [7:0] entry_bcd;
  logic       entry_neg;

  int n_cmp;
  int n_bad;
  int cyc;
  bit saw_vv;

  dec_entry #(.WIDTH(6), .DIGITS(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .sgn         (sgn),
    .value       (value),
    .value_valid (value_valid),
    .err         (err),
    .busy        (busy),
    .entry_bcd   (entry_bcd),
    .entry_neg   (entry_neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic key(input logic [3:0] c);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = c;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'hD;
  endtask

  // Counts negedges with busy high after an accepted enter.
  task automatic run(output int n);
    n = 0;
    while (busy && n < 30) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'hD;
    sgn       = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_value", 32'(value), 32'h0);
    chk("rst_vv", 32'(value_valid), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_bcd", 32'(entry_bcd), 32'hFF);
    chk("rst_neg", 32'(entry_neg), 32'h0);
    rst_n = 1'b1;

    key(4'd4); key(4'd2);
    chk("t1_bcd", 32'(entry_bcd), 32'h42);
    sgn = 1'b0;
    key(4'hE);
    chk("t1_busy", 32'(busy), 32'h1);
    run(cyc);
    chk("t1_lat", 32'(cyc), 32'd9);
    chk("t1_vv", 32'(value_valid), 32'h1);
    chk("t1_value", 32'(value), 32'h2A);
    chk("t1_err", 32'(err), 32'h0);
    @(negedge clk);
    chk("t1_vv_pulse", 32'(value_valid), 32'h0);

    sgn = 1'b1;
    key(4'd3); key(4'd2); key(4'hA);
    chk("t2_neg", 32'(entry_neg), 32'h1);
    key(4'hE);
    run(cyc);
    chk("t2_vv", 32'(value_valid), 32'h1);
    chk("t2_value", 32'(value), 32'h20);
    chk("t2_err", 32'(err), 32'h0);

    key(4'd3); key(4'd2); key(4'hE);
    run(cyc);
    chk("t3_lat", 32'(cyc), 32'd9);
    chk("t3_err", 32'(err), 32'h1);
    chk("t3_vv", 32'(value_valid), 32'h0);
    chk("t3_value", 32'(value), 32'h20);

    sgn = 1'b0;
    key(4'd9);
    chk("t4_err_clr", 32'(err), 32'h0);
    key(4'd9); key(4'd7);
    chk("t4_bcd", 32'(entry_bcd), 32'h99);
    key(4'hE);
    run(cyc);
    chk("t4_err", 32'(err), 32'h1);
    chk("t4_vv", 32'(value_valid), 32'h0);

    key(4'd5);
    key(4'hE);
    repeat (2) @(negedge clk);
    chk("t5_busy_mid", 32'(busy), 32'h1);
    key(4'hC);
    chk("t5_busy", 32'(busy), 32'h0);
    chk("t5_bcd", 32'(entry_bcd), 32'hFF);
    saw_vv = value_valid;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (value_valid) saw_vv = 1'b1;
    end
    chk("t5_no_vv", 32'(saw_vv), 32'h0);
    chk("t5_value", 32'(value), 32'h20);

    key(4'hE);
    run(cyc);
    chk("t6_lat", 32'(cyc), 32'd9);
    chk("t6_vv", 32'(value_valid), 32'h1);
    chk("t6_value", 32'(value), 32'h0);
    sgn = 1'b0;
    key(4'hA);
    chk("t6_neg_uns", 32'(entry_neg), 32'h0);

    sgn = 1'b1;
    key(4'd0); key(4'hA); key(4'hE);
    run(cyc);
    chk("t7_vv", 32'(value_valid), 32'h1);
    chk("t7_negzero", 32'(value), 32'h0);

    key(4'd3); key(4'd1); key(4'hE);
    run(cyc);
    chk("t8_vv", 32'(value_valid), 32'h1);
    chk("t8_value", 32'(value), 32'h1F);

    key(4'd3); key(4'd3); key(4'hA); key(4'hE);
    run(cyc);
    chk("t9_err", 32'(err), 32'h1);
    chk("t9_value", 32'(value), 32'h1F);

    sgn = 1'b0;
    key(4'd6); key(4'd3); key(4'hE);
    run(cyc);
    chk("t10_vv", 32'(value_valid), 32'h1);
    chk("t10_value", 32'(value), 32'h3F);
    chk("t10_err", 32'(err), 32'h0);

    key(4'd6); key(4'd4); key(4'hE);
    run(cyc);
    chk("t10b_err", 32'(err), 32'h1);
    chk("t10b_value", 32'(value), 32'h3F);

    key(4'hC);
    key(4'd1); key(4'd7);
    chk("t11_bcd0", 32'(entry_bcd), 32'h17);
    key(4'hB);
`ifdef DEC_ENTRY_BACKSPACE_EN
    chk("t11_bcd1", 32'(entry_bcd), 32'hF1);
`else
    chk("t11_bcd1", 32'(entry_bcd), 32'h17);
`endif
    key(4'd5);
`ifdef DEC_ENTRY_BACKSPACE_EN
    chk("t11_bcd2", 32'(entry_bcd), 32'h15);
`else
    chk("t11_bcd2", 32'(entry_bcd), 32'h17);
`endif
    key(4'hE);
    run(cyc);
    chk("t11_vv", 32'(value_valid), 32'h1);
`ifdef DEC_ENTRY_BACKSPACE_EN
    chk("t11_value", 32'(value), 32'd15);
`else
    chk("t11_value", 32'(value), 32'd17);
`endif
    chk("t11_bcd_done", 32'(entry_bcd), 32'(entry_bcd == 8'h15 ? 8'h15 : 8'h17));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
